// File: rtl/cpu_core_p.sv
// rtl/cpu_core_p.sv - parametrised accumulator core with flags, branches and a wait-state bus
module cpu_core_p #(
  parameter int            DW       = 8,
  parameter int            AW       = 16,
  parameter int            NREG     = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] addr,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] wdata,
  output logic          re,
  output logic          we,
  input  logic          ready,
  output logic          halted
);

  localparam int AWORDS = (AW + DW - 1) / DW;
  localparam int CW     = (AWORDS > 1) ? $clog2(AWORDS) : 1;

  localparam logic [2:0] S_RST   = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_OPND  = 3'd3;
  localparam logic [2:0] S_MEMRD = 3'd4;
  localparam logic [2:0] S_MEMWR = 3'd5;
  localparam logic [2:0] S_HALT  = 3'd6;

  logic [2:0]    state;
  logic [AW-1:0] pc;
  logic [7:0]    op;
  logic [AW-1:0] opnd;
  logic [CW-1:0] cnt;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [DW-1:0] regs [NREG];
  logic          fz;
  logic          fc;
  logic          fn;

  function automatic logic has_opnd(input logic [7:0] o);
    return (o == 8'h02) || (o == 8'h03) || (o == 8'h04) ||
           ((o >= 8'h50) && (o <= 8'h54));
  endfunction

  function automatic logic is_addr_op(input logic [7:0] o);
    return has_opnd(o) && (o != 8'h02);
  endfunction

  // Address operands arrive most-significant word first; the shift keeps only AW bits.
  logic [AW-1:0] opnd_next;
  logic          last_word;
  logic          br_take;

  always_comb begin
    opnd_next = AW'({opnd, rdata});
    last_word = !is_addr_op(op) || (cnt == CW'(AWORDS - 1));
    case (op)
      8'h50:   br_take = 1'b1;
      8'h51:   br_take = fz;
      8'h52:   br_take = !fz;
      8'h53:   br_take = fc;
      8'h54:   br_take = fn;
      default: br_take = 1'b0;
    endcase
  end

  logic [DW:0]   ext;
  logic [DW-1:0] alu_res;
  logic          alu_c;
  logic          alu_valid;
  logic          alu_wr;

  always_comb begin
    ext       = '0;
    alu_res   = a;
    alu_c     = fc;
    alu_valid = (op[7:4] == 4'h4) && (op[3:0] <= 4'h9);
    alu_wr    = alu_valid && (op[3:0] != 4'h9);
    case (op[3:0])
      4'h0: begin
        ext     = {1'b0, a} + {1'b0, b};
        alu_res = ext[DW-1:0];
        alu_c   = ext[DW];
      end
      4'h1: begin
        ext     = {1'b0, a} + {1'b0, b} + (DW+1)'(fc);
        alu_res = ext[DW-1:0];
        alu_c   = ext[DW];
      end
      4'h2, 4'h9: begin
        ext     = {1'b0, a} - {1'b0, b};
        alu_res = ext[DW-1:0];
        alu_c   = ext[DW];
      end
      4'h3: alu_res = a & b;
      4'h4: alu_res = a | b;
      4'h5: alu_res = a ^ b;
      4'h6: alu_res = ~a;
      4'h7: begin
        alu_res = {a[DW-2:0], 1'b0};
        alu_c   = a[DW-1];
      end
      4'h8: begin
        alu_res = {1'b0, a[DW-1:1]};
        alu_c   = a[0];
      end
      default: alu_res = a;
    endcase
  end

  // Register numbers at or above NREG select nothing, turning 0x1r-0x3r into NOPs.
  logic [DW-1:0] reg_rd;
  logic          reg_hit;

  always_comb begin
    reg_rd  = '0;
    reg_hit = int'(op[3:0]) < NREG;
    for (int i = 0; i < NREG; i++) begin
      if (op[3:0] == 4'(i)) reg_rd = regs[i];
    end
  end

  assign re     = (state == S_FETCH) || (state == S_OPND) || (state == S_MEMRD);
  assign we     = (state == S_MEMWR);
  assign addr   = ((state == S_MEMRD) || (state == S_MEMWR)) ? opnd : pc;
  assign wdata  = (state == S_MEMWR) ? a : '0;
  assign halted = (state == S_HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_RST;
      pc    <= RESET_PC;
      op    <= '0;
      opnd  <= '0;
      cnt   <= '0;
      a     <= '0;
      b     <= '0;
      fz    <= 1'b0;
      fc    <= 1'b0;
      fn    <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_RST: state <= S_FETCH;

        S_FETCH: begin
          if (ready) begin
            op  <= rdata[7:0];
            pc  <= pc + AW'(1);
            cnt <= '0;
            if (has_opnd(rdata[7:0]))   state <= S_OPND;
            else if (rdata[7:0] == 8'h01) state <= S_HALT;
            else                          state <= S_EXEC;
          end
        end

        S_EXEC: begin
          state <= S_FETCH;
          if (alu_valid) begin
            fz <= (alu_res == '0);
            fn <= alu_res[DW-1];
            fc <= alu_c;
            if (alu_wr) a <= alu_res;
          end
          if (reg_hit) begin
            case (op[7:4])
              4'h1: begin
                for (int i = 0; i < NREG; i++) begin
                  if (op[3:0] == 4'(i)) regs[i] <= a;
                end
              end
              4'h2:    a <= reg_rd;
              4'h3:    b <= reg_rd;
              default: ;
            endcase
          end
        end

        S_OPND: begin
          if (ready) begin
            pc   <= pc + AW'(1);
            opnd <= opnd_next;
            cnt  <= cnt + CW'(1);
            if (last_word) begin
              case (op)
                8'h02: begin
                  a     <= rdata;
                  state <= S_FETCH;
                end
                8'h03:   state <= S_MEMRD;
                8'h04:   state <= S_MEMWR;
                default: begin
                  if (br_take) pc <= opnd_next;
                  state <= S_FETCH;
                end
              endcase
            end
          end
        end

        S_MEMRD: begin
          if (ready) begin
            a     <= rdata;
            state <= S_FETCH;
          end
        end

        S_MEMWR: begin
          if (ready) state <= S_FETCH;
        end

        S_HALT: state <= S_HALT;

        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core_p.sv
// tb/tb_cpu_core_p.sv - scoreboard bench for cpu_core_p (default build and a 16/20/4 build)
module tb_cpu_core_p;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr;
  logic [7:0]  rdata = '0;
  logic [7:0]  wdata;
  logic        re, we, halted;
  logic        ready = 1'b0;
  logic [19:0] addr2;
  logic [15:0] rdata2 = '0;
  logic [15:0] wdata2;
  logic        re2, we2, halted2;
  logic        ready2 = 1'b0;

  always #5 clk = ~clk;

  cpu_core_p dut (
    .clk(clk), .rst(rst), .addr(addr), .rdata(rdata), .wdata(wdata),
    .re(re), .we(we), .ready(ready), .halted(halted)
  );

  cpu_core_p #(.DW(16), .AW(20), .NREG(4), .RESET_PC(20'h00010)) dut2 (
    .clk(clk), .rst(rst), .addr(addr2), .rdata(rdata2), .wdata(wdata2),
    .re(re2), .we(we2), .ready(ready2), .halted(halted2)
  );

  logic [7:0]  mem1 [0:65535];
  logic [15:0] mem2 [int];
  logic [23:0] q1 [$];
  logic [35:0] q2 [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          wp;
  logic        cur_halt, cur_halt2;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic org(input int a);
    wp = a;
  endtask

  task automatic e(input logic [7:0] d);
    mem1[wp] = d;
    wp++;
  endtask

  task automatic clear_mem();
    foreach (mem1[i]) mem1[i] = 8'h00;
    mem2.delete();
    q1.delete();
    q2.delete();
  endtask

  // One clock: drive ready, serve reads, and retire completing writes against the queues.
  task automatic step(input logic r1, input logic r2);
    logic [23:0] e1;
    logic [35:0] e2;
    @(negedge clk);
    ready  = r1;
    ready2 = r2;
    #1;
    rdata  = mem1[addr];
    rdata2 = mem2.exists(int'(addr2)) ? mem2[int'(addr2)] : 16'h0000;
    cur_halt  = halted;
    cur_halt2 = halted2;
    if (we && ready) begin
      mem1[addr] = wdata;
      n_vec++;
      if (q1.size() == 0) begin
        n_err++;
        $display("FAIL wr1_unexpected: got addr=%h data=%h, required no write", addr, wdata);
      end else begin
        e1 = q1.pop_front();
        if ({addr, wdata} !== e1) begin
          n_err++;
          $display("FAIL wr1: got addr=%h data=%h, required addr=%h data=%h", addr, wdata, e1[23:8], e1[7:0]);
        end
      end
    end
    if (we2 && ready2) begin
      mem2[int'(addr2)] = wdata2;
      n_vec++;
      if (q2.size() == 0) begin
        n_err++;
        $display("FAIL wr2_unexpected: got addr=%h data=%h, required no write", addr2, wdata2);
      end else begin
        e2 = q2.pop_front();
        if ({addr2, wdata2} !== e2) begin
          n_err++;
          $display("FAIL wr2: got addr=%h data=%h, required addr=%h data=%h", addr2, wdata2, e2[35:16], e2[15:0]);
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; ready = 1'b0; ready2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_until_halt(input int max, output int n);
    n = 0;
    cur_halt = 1'b0;
    while (!cur_halt && n < max) begin
      step(1'b1, 1'b0);
      n++;
    end
    if (!cur_halt) begin
      n_vec++; n_err++;
      $display("FAIL halt_timeout: no halt within %0d cycles, required halt", max);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec += 7;
    if (re !== 1'b0)          begin n_err++; $display("FAIL rst_re: got %b required 0", re); end
    if (we !== 1'b0)          begin n_err++; $display("FAIL rst_we: got %b required 0", we); end
    if (addr !== 16'h0000)    begin n_err++; $display("FAIL rst_addr: got %h required 0000", addr); end
    if (wdata !== 8'h00)      begin n_err++; $display("FAIL rst_wdata: got %h required 00", wdata); end
    if (halted !== 1'b0)      begin n_err++; $display("FAIL rst_halted: got %b required 0", halted); end
    if (addr2 !== 20'h00010)  begin n_err++; $display("FAIL rst_addr2: got %h required 00010", addr2); end
    if (re2 !== 1'b0)         begin n_err++; $display("FAIL rst_re2: got %b required 0", re2); end
  endtask

  task automatic test_ldi_tar_hlt();
    int n;
    clear_mem();
    org(0);
    e(8'h02); e(8'h5A); e(8'h13); e(8'h02); e(8'h00); e(8'h23);
    e(8'h04); e(8'h01); e(8'h00); e(8'h01);
    q1.push_back({16'h0100, 8'h5A});
    do_reset();
    run_until_halt(50, n);
    n_vec++;
    if (n !== 14) begin n_err++; $display("FAIL halt_cycle: got %0d required 14", n); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      n_vec++;
      if (re !== 1'b0 || we !== 1'b0 || halted !== 1'b1) begin
        n_err++; $display("FAIL halt_hold: got re=%b we=%b halted=%b required 0 0 1", re, we, halted);
      end
    end
    n_vec++;
    if (q1.size() !== 0) begin n_err++; $display("FAIL ldi_pending: got %0d writes left required 0", q1.size()); end
  endtask

  task automatic test_alu_flags();
    int n;
    clear_mem();
    org(8'h00);
    e(8'h02); e(8'hFF); e(8'h10); e(8'h02); e(8'h01); e(8'h11); e(8'h31); e(8'h20);
    e(8'h40); e(8'h04); e(8'h02); e(8'h00); e(8'h51); e(8'h00); e(8'h10); e(8'h01);
    org(8'h10);
    e(8'h53); e(8'h00); e(8'h14); e(8'h01);
    org(8'h14);
    e(8'h54); e(8'h00); e(8'h30); e(8'h41); e(8'h04); e(8'h02); e(8'h01);
    e(8'h53); e(8'h00); e(8'h30); e(8'h52); e(8'h00); e(8'h40); e(8'h01);
    org(8'h30);
    e(8'h01);
    org(8'h40);
    e(8'h04); e(8'h02); e(8'h02); e(8'h46); e(8'h53); e(8'h00); e(8'h30);
    e(8'h54); e(8'h00); e(8'h50); e(8'h01);
    org(8'h50);
    e(8'h04); e(8'h02); e(8'h03); e(8'h48); e(8'h53); e(8'h00); e(8'h60); e(8'h01);
    org(8'h60);
    e(8'h04); e(8'h02); e(8'h04); e(8'h01);
    q1.push_back({16'h0200, 8'h00});
    q1.push_back({16'h0201, 8'h02});
    q1.push_back({16'h0202, 8'h02});
    q1.push_back({16'h0203, 8'hFD});
    q1.push_back({16'h0204, 8'h7E});
    do_reset();
    run_until_halt(300, n);
    n_vec++;
    if (q1.size() !== 0) begin n_err++; $display("FAIL alu_pending: got %0d writes left required 0", q1.size()); end
  endtask

  task automatic test_cmp_branch();
    int n;
    clear_mem();
    org(0);
    e(8'h02); e(8'h10); e(8'h12); e(8'h32); e(8'h49);
    e(8'h52); e(8'h12); e(8'h34); e(8'h51); e(8'h12); e(8'h34);
    org(16'h1234);
    e(8'h04); e(8'h03); e(8'h00); e(8'h01);
    q1.push_back({16'h0300, 8'h10});
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      step(1'b1, 1'b0);
      if (i == 9) begin
        n_vec++;
        if (addr !== 16'h0005 || re !== 1'b1) begin n_err++; $display("FAIL bnz_fetch: got %h re=%b required 0005 re=1", addr, re); end
      end
      if (i == 12) begin
        n_vec++;
        if (addr !== 16'h0008 || re !== 1'b1) begin n_err++; $display("FAIL bnz_fall: got %h re=%b required 0008 re=1", addr, re); end
      end
      if (i == 15) begin
        n_vec++;
        if (addr !== 16'h1234 || re !== 1'b1) begin n_err++; $display("FAIL bz_target: got %h re=%b required 1234 re=1", addr, re); end
      end
    end
    run_until_halt(50, n);
    n_vec++;
    if (q1.size() !== 0) begin n_err++; $display("FAIL cmp_pending: got %0d writes left required 0", q1.size()); end
  endtask

  task automatic test_stm_wait();
    int n;
    clear_mem();
    org(0);
    e(8'h02); e(8'hC3); e(8'h04); e(8'h08); e(8'h00); e(8'h01);
    q1.push_back({16'h0800, 8'hC3});
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step((i >= 6 && i <= 8) ? 1'b0 : 1'b1, 1'b0);
      if (i >= 6 && i <= 9) begin
        n_vec += 3;
        if (we !== 1'b1 || re !== 1'b0) begin n_err++; $display("FAIL stm_we: cycle %0d got we=%b re=%b required 1 0", i, we, re); end
        if (addr !== 16'h0800)          begin n_err++; $display("FAIL stm_addr: cycle %0d got %h required 0800", i, addr); end
        if (wdata !== 8'hC3)            begin n_err++; $display("FAIL stm_wdata: cycle %0d got %h required c3", i, wdata); end
      end
      if (i == 10) begin
        n_vec++;
        if (we !== 1'b0 || re !== 1'b1 || addr !== 16'h0005) begin
          n_err++; $display("FAIL stm_after: got we=%b re=%b addr=%h required 0 1 0005", we, re, addr);
        end
      end
    end
    run_until_halt(20, n);
    n_vec++;
    if (q1.size() !== 0) begin n_err++; $display("FAIL stm_pending: got %0d writes left required 0", q1.size()); end
  endtask

  task automatic test_reset_mid_access();
    int n;
    clear_mem();
    org(0);
    e(8'h03); e(8'h04); e(8'h00); e(8'h04); e(8'h05); e(8'h00); e(8'h01);
    mem1[16'h0400] = 8'h99;
    do_reset();
    for (int i = 1; i <= 4; i++) step((i == 4) ? 1'b0 : 1'b1, 1'b0);
    n_vec++;
    if (re !== 1'b1 || addr !== 16'h0400) begin n_err++; $display("FAIL ldm_memrd: got re=%b addr=%h required 1 0400", re, addr); end
    rst = 1'b0;
    #1;
    n_vec++;
    if (re !== 1'b0 || we !== 1'b0 || addr !== 16'h0000) begin
      n_err++; $display("FAIL rst_mid: got re=%b we=%b addr=%h required 0 0 0000", re, we, addr);
    end
    clear_mem();
    org(0);
    e(8'h04); e(8'h05); e(8'h00); e(8'h01);
    q1.push_back({16'h0500, 8'h00});
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b0);
    n_vec++;
    if (re !== 1'b1 || addr !== 16'h0000) begin n_err++; $display("FAIL rst_refetch: got re=%b addr=%h required 1 0000", re, addr); end
    run_until_halt(20, n);
    n_vec++;
    if (q1.size() !== 0) begin n_err++; $display("FAIL rstmid_pending: got %0d writes left required 0", q1.size()); end
  endtask

  task automatic test_wide_build();
    int k;
    clear_mem();
    mem2[20'h00000] = 16'h0001;
    mem2[20'h00010] = 16'h0003; mem2[20'h00011] = 16'hABCD; mem2[20'h00012] = 16'h1234;
    mem2[20'h00013] = 16'h0004; mem2[20'h00014] = 16'h0000; mem2[20'h00015] = 16'h0100;
    mem2[20'h00016] = 16'h0015;
    mem2[20'h00017] = 16'h0021;
    mem2[20'h00018] = 16'h0004; mem2[20'h00019] = 16'hFFF0; mem2[20'h0001A] = 16'h0101;
    mem2[20'h0001B] = 16'h0050; mem2[20'h0001C] = 16'h000F; mem2[20'h0001D] = 16'hFFFF;
    mem2[20'hD1234] = 16'hBEEF;
    mem2[20'hFFFFF] = 16'h0000;
    q2.push_back({20'h00100, 16'hBEEF});
    q2.push_back({20'h00101, 16'h0000});
    do_reset();
    k = 0;
    cur_halt2 = 1'b0;
    while (!cur_halt2 && k < 40) begin
      step(1'b0, 1'b1);
      k++;
      if (k == 1) begin
        n_vec++;
        if (addr2 !== 20'h00010 || re2 !== 1'b1) begin n_err++; $display("FAIL w_first: got %h re=%b required 00010 re=1", addr2, re2); end
      end
      if (k == 4) begin
        n_vec++;
        if (addr2 !== 20'hD1234 || re2 !== 1'b1) begin n_err++; $display("FAIL w_ldm_addr: got %h re=%b required d1234 re=1", addr2, re2); end
      end
      if (k == 20) begin
        n_vec++;
        if (addr2 !== 20'hFFFFF || re2 !== 1'b1) begin n_err++; $display("FAIL w_top_fetch: got %h re=%b required fffff re=1", addr2, re2); end
      end
      if (k == 22) begin
        n_vec++;
        if (addr2 !== 20'h00000 || re2 !== 1'b1) begin n_err++; $display("FAIL w_wrap: got %h re=%b required 00000 re=1", addr2, re2); end
      end
    end
    n_vec += 2;
    if (k !== 23) begin n_err++; $display("FAIL w_halt_cycle: got %0d required 23", k); end
    if (q2.size() !== 0) begin n_err++; $display("FAIL w_pending: got %0d writes left required 0", q2.size()); end
  endtask

  initial begin
    test_reset();
    test_ldi_tar_hlt();
    test_alu_flags();
    test_cmp_branch();
    test_stm_wait();
    test_reset_mid_access();
    test_wide_build();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
